fault_sim_sequencer: RTL

//  Hardware sequencer for serial stuck-at fault simulation of a netlist-under-test (s298 class).

---
 rtl/fsim_pkg.sv | 25 ++
 rtl/fault_sim_sequencer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/fsim_pkg.sv
// Shared types for the serial stuck-at fault simulation sequencer.
// Holds the FSM state encoding and the fault-list record layout.
package fsim_pkg;

    localparam int FID_W_DFLT = 8;

    typedef enum logic [3:0] {
        IDLE,
        FRD,
        FCAP,
        TRD,
        TCAP,
        WAIT,
        CMP,
        FEND,
        REMOVE,
        FDONE
    } state_e;

    typedef struct packed {
        logic [FID_W_DFLT-1:0] fid;
        logic                  sa;
    } flt_rec_t;

endpackage

// File: rtl/fault_sim_sequencer.sv
// Serial stuck-at fault simulation sequencer: walks faults, then vectors,
// comparing golden and fault-injected outputs with early exit on detection.
module fault_sim_sequencer
    import fsim_pkg::*;
#(
    parameter int NUM_PI = 3,
    parameter int NUM_PO = 6,
    parameter int FLT_AW = 8,
    parameter int TV_AW  = 8,
    parameter int FID_W  = FID_W_DFLT,
    parameter int SETTLE = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [FLT_AW:0]   num_faults,
    input  logic [TV_AW:0]    num_vectors,
    output logic [FLT_AW-1:0] flt_addr,
    input  logic [FID_W:0]    flt_rdata,
    output logic [TV_AW-1:0]  tv_addr,
    input  logic [NUM_PI-1:0] tv_rdata,
    output logic [NUM_PI-1:0] pi_vec,
    output logic              inj_en,
    output logic [FID_W-1:0]  inj_id,
    output logic              inj_val,
    input  logic [NUM_PO-1:0] good_po,
    input  logic [NUM_PO-1:0] fault_po,
    output logic              res_valid,
    output logic              res_det,
    output logic [TV_AW-1:0]  res_tv,
    output logic [FLT_AW:0]   fault_cnt,
    output logic [FLT_AW:0]   det_cnt,
    output logic              busy,
    output logic              done
);

    localparam int FW = FLT_AW + 1;
    localparam int TW = TV_AW + 1;
    localparam int SW = $clog2(SETTLE + 1);

    state_e              state_q, state_d;
    logic [FW-1:0]       nf_q, nf_d;
    logic [TW-1:0]       nv_q, nv_d;
    logic [FW-1:0]       fi_q, fi_d;
    logic [TW-1:0]       ti_q, ti_d;
    logic [SW-1:0]       settle_q, settle_d;
    logic [NUM_PI-1:0]   pi_q, pi_d;
    logic                inj_en_q, inj_en_d;
    logic [FID_W-1:0]    inj_id_q, inj_id_d;
    logic                inj_val_q, inj_val_d;
    logic                det_q, det_d;
    logic [TV_AW-1:0]    res_tv_q, res_tv_d;
    logic [FW-1:0]       fcnt_q, fcnt_d;
    logic [FW-1:0]       dcnt_q, dcnt_d;
    logic                done_q, done_d;

    // State and datapath registers; reset aborts any run in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            nf_q      <= '0;
            nv_q      <= '0;
            fi_q      <= '0;
            ti_q      <= '0;
            settle_q  <= '0;
            pi_q      <= '0;
            inj_en_q  <= 1'b0;
            inj_id_q  <= '0;
            inj_val_q <= 1'b0;
            det_q     <= 1'b0;
            res_tv_q  <= '0;
            fcnt_q    <= '0;
            dcnt_q    <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            nf_q      <= nf_d;
            nv_q      <= nv_d;
            fi_q      <= fi_d;
            ti_q      <= ti_d;
            settle_q  <= settle_d;
            pi_q      <= pi_d;
            inj_en_q  <= inj_en_d;
            inj_id_q  <= inj_id_d;
            inj_val_q <= inj_val_d;
            det_q     <= det_d;
            res_tv_q  <= res_tv_d;
            fcnt_q    <= fcnt_d;
            dcnt_q    <= dcnt_d;
            done_q    <= done_d;
        end
    end

    // Next-state and datapath update; last clean vector exits straight to FEND
    always_comb begin
        state_d   = state_q;
        nf_d      = nf_q;
        nv_d      = nv_q;
        fi_d      = fi_q;
        ti_d      = ti_q;
        settle_d  = settle_q;
        pi_d      = pi_q;
        inj_en_d  = inj_en_q;
        inj_id_d  = inj_id_q;
        inj_val_d = inj_val_q;
        det_d     = det_q;
        res_tv_d  = res_tv_q;
        fcnt_d    = fcnt_q;
        dcnt_d    = dcnt_q;
        done_d    = done_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    nf_d   = num_faults;
                    nv_d   = num_vectors;
                    fi_d   = '0;
                    ti_d   = '0;
                    fcnt_d = '0;
                    dcnt_d = '0;
                    done_d = 1'b0;
                    state_d = (num_faults == '0) ? FDONE : FRD;
                end
            end
            FRD: state_d = FCAP;
            FCAP: begin
                inj_id_d  = flt_rdata[FID_W:1];
                inj_val_d = flt_rdata[0];
                inj_en_d  = 1'b1;
                det_d     = 1'b0;
                state_d   = TRD;
            end
            TRD: state_d = (ti_q == nv_q) ? FEND : TCAP;
            TCAP: begin
                pi_d     = tv_rdata;
                settle_d = '0;
                state_d  = WAIT;
            end
            WAIT: begin
                if (settle_q == SW'(SETTLE - 1)) begin
                    state_d = CMP;
                end else begin
                    settle_d = settle_q + SW'(1);
                end
            end
            CMP: begin
                if (good_po != fault_po) begin
                    det_d    = 1'b1;
                    res_tv_d = ti_q[TV_AW-1:0];
                    state_d  = FEND;
                end else if (ti_q + TW'(1) == nv_q) begin
                    state_d = FEND;
                end else begin
                    ti_d    = ti_q + TW'(1);
                    state_d = TRD;
                end
            end
            FEND: begin
                fcnt_d   = fcnt_q + FW'(1);
                dcnt_d   = dcnt_q + FW'(det_q);
                inj_en_d = 1'b0;
                ti_d     = '0;
                if (fi_q + FW'(1) == nf_q) begin
                    state_d = FDONE;
                end else begin
                    fi_d    = fi_q + FW'(1);
                    state_d = REMOVE;
                end
            end
            REMOVE: state_d = FRD;
            FDONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign flt_addr  = fi_q[FLT_AW-1:0];
    assign tv_addr   = ti_q[TV_AW-1:0];
    assign pi_vec    = pi_q;
    assign inj_en    = inj_en_q;
    assign inj_id    = inj_id_q;
    assign inj_val   = inj_val_q;
    assign res_valid = (state_q == FEND);
    assign res_det   = res_valid & det_q;
    assign res_tv    = res_tv_q;
    assign fault_cnt = fcnt_q;
    assign det_cnt   = dcnt_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;

endmodule
